// File: rtl/a2b_packet_router_pkg.sv
// ============================================================================
// a2b_packet_router_pkg : shared packet codes, header layout and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package a2b_packet_router_pkg;

  localparam int c_TYPE_MSB = 31;
  localparam int c_TYPE_LSB = 28;
  localparam int c_CODE_MSB = 27;
  localparam int c_CODE_LSB = 24;
  localparam int c_SLEN_MSB = 23;
  localparam int c_SLEN_LSB = 15;
  localparam int c_LEN_W    = 11;

  localparam logic [3:0] c_TYPE_CORRECT_PARITY = 4'h1;
  localparam logic [3:0] c_TYPE_TARGET_HASHTAG = 4'h2;
  localparam logic [3:0] c_TYPE_EV_RANDOMBIT   = 4'h3;

  localparam logic [3:0] c_LEN_257  = 4'h1;
  localparam logic [3:0] c_LEN_514  = 4'h2;
  localparam logic [3:0] c_LEN_771  = 4'h3;
  localparam logic [3:0] c_LEN_1028 = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [c_LEN_W-1:0] payload_len(input logic [3:0] code,
                                                     input logic [8:0] slen);
    case (code)
      c_LEN_257:  return {2'b00, slen};
      c_LEN_514:  return 11'd512;
      c_LEN_771:  return 11'd768;
      c_LEN_1028: return 11'd1024;
      default:    return 11'd1024;
    endcase
  endfunction

  function automatic logic is_er_type(input logic [3:0] ptype);
    return (ptype == c_TYPE_CORRECT_PARITY) || (ptype == c_TYPE_TARGET_HASHTAG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/a2b_packet_router_if.sv
// ============================================================================
// a2b_packet_router_if : source FIFO, ER FIFO and EV BRAM signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface a2b_packet_router_if #(
  parameter int DATA_W     = 32,
  parameter int PACK_RATIO = 2,
  parameter int EV_ADDR_W  = 14
);
  logic                           src_empty;
  logic [DATA_W-1:0]              src_dout;
  logic                           src_rd_en;
  logic                           er_full;
  logic                           er_wr_en;
  logic [DATA_W-1:0]              er_wr_din;
  logic [PACK_RATIO*DATA_W/8-1:0] ev_wea;
  logic [EV_ADDR_W-1:0]           ev_addra;
  logic [PACK_RATIO*DATA_W-1:0]   ev_dina;

  modport master (
    input  src_empty, src_dout, er_full,
    output src_rd_en, er_wr_en, er_wr_din, ev_wea, ev_addra, ev_dina
  );

  modport slave (
    output src_empty, src_dout, er_full,
    input  src_rd_en, er_wr_en, er_wr_din, ev_wea, ev_addra, ev_dina
  );
endinterface

`default_nettype wire

// File: rtl/a2b_word_packer.sv
// ============================================================================
// a2b_word_packer : packs DATA_W words MSB-first into one wide BRAM word
// Revision: 1.0
// ============================================================================
`default_nettype none

module a2b_word_packer #(
  parameter int DATA_W     = 32,
  parameter int PACK_RATIO = 2
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           i_push,
  input  wire logic                           i_last,
  input  wire logic [DATA_W-1:0]              i_data,
  output logic      [PACK_RATIO*DATA_W/8-1:0] o_we,
  output logic      [PACK_RATIO*DATA_W-1:0]   o_data
);
  localparam int c_IDX_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

  logic [PACK_RATIO*DATA_W-1:0] r_buf;
  logic [c_IDX_W-1:0]           r_idx;
  logic [PACK_RATIO*DATA_W-1:0] w_merged;
  logic                         w_flush;

  // Unfilled low slices stay zero, which pads a short final group.
  always_comb begin
    w_merged = r_buf;
    w_merged[(PACK_RATIO - 1 - int'(r_idx)) * DATA_W +: DATA_W] = i_data;
    w_flush  = i_push && (i_last || (int'(r_idx) == PACK_RATIO - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_idx  <= '0;
      o_we   <= '0;
      o_data <= '0;
    end else begin
      o_we <= '0;
      if (w_flush) begin
        o_we   <= '1;
        o_data <= w_merged;
        r_buf  <= '0;
        r_idx  <= '0;
      end else if (i_push) begin
        r_buf <= w_merged;
        r_idx <= r_idx + c_IDX_W'(1);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/a2b_packet_router.sv
// ============================================================================
// a2b_packet_router : routes source packets to the ER FIFO or packed EV BRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module a2b_packet_router
  import a2b_packet_router_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PACK_RATIO   = 2,
  parameter int EV_ADDR_W    = 14,
  parameter int EV_PKT_LIMIT = 32,
  parameter int LEN_W        = 11
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clear_ev,
  a2b_packet_router_if.master bus,
  output logic              ev_full,
  output logic              pkt_done,
  output logic              pkt_drop,
  output logic [2:0]        state
);
  localparam int c_CNT_W = $clog2(EV_PKT_LIMIT + 1);

  state_e                       r_state;
  logic [DATA_W-1:0]            r_hdr;
  logic [LEN_W-1:0]             r_remain;
  logic [c_CNT_W-1:0]           r_ev_cnt;
  logic [EV_ADDR_W-1:0]         r_ev_addr;
  logic                         r_pkt_done;
  logic                         r_pkt_drop;

  logic [3:0]                   w_type;
  logic                         w_is_er;
  logic                         w_is_ev;
  logic                         w_have;
  logic                         w_last;
  logic                         w_pop;
  logic                         w_er_wr;
  logic [DATA_W-1:0]            w_er_din;
  logic                         w_ev_push;
  logic [PACK_RATIO*DATA_W/8-1:0] w_ev_we;
  logic [PACK_RATIO*DATA_W-1:0] w_ev_data;

  assign w_type  = r_hdr[c_TYPE_MSB:c_TYPE_LSB];
  assign w_is_er = is_er_type(w_type);
  assign w_is_ev = (w_type == c_TYPE_EV_RANDOMBIT);
  assign w_have  = (r_remain != '0);
  assign w_last  = (r_remain == LEN_W'(1));
  assign ev_full = (r_ev_cnt == c_CNT_W'(EV_PKT_LIMIT));

  // Source pops are held off during reset so no word is lost across it.
  always_comb begin
    w_pop    = 1'b0;
    w_er_wr  = 1'b0;
    w_er_din = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:   w_pop = !bus.src_empty;
        ST_HEADER: begin
          if (w_is_er && !bus.er_full) begin
            w_er_wr  = 1'b1;
            w_er_din = r_hdr;
          end
        end
        ST_PAYLOAD: begin
          if (w_is_er) begin
            w_pop    = !bus.src_empty && !bus.er_full && w_have;
            w_er_wr  = w_pop;
            w_er_din = w_pop ? bus.src_dout : '0;
          end else begin
            w_pop = !bus.src_empty && w_have;
          end
        end
        ST_DROP:   w_pop = !bus.src_empty && w_have;
        default:   w_pop = 1'b0;
      endcase
    end
  end

  assign w_ev_push = (r_state == ST_PAYLOAD) && !w_is_er && w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hdr      <= '0;
      r_remain   <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_drop <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_hdr    <= bus.src_dout;
            r_remain <= LEN_W'(payload_len(bus.src_dout[c_CODE_MSB:c_CODE_LSB],
                                           bus.src_dout[c_SLEN_MSB:c_SLEN_LSB]));
            r_state  <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (w_is_er) begin
            if (!bus.er_full) r_state <= ST_PAYLOAD;
          end else if (w_is_ev && !ev_full) begin
            r_state <= ST_PAYLOAD;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (!w_have || (w_pop && w_last)) begin
            r_state    <= ST_DONE;
            r_pkt_done <= 1'b1;
          end
          if (w_pop) r_remain <= r_remain - LEN_W'(1);
        end
        ST_DROP: begin
          if (!w_have || (w_pop && w_last)) begin
            r_state    <= ST_DONE;
            r_pkt_done <= 1'b1;
            r_pkt_drop <= 1'b1;
          end
          if (w_pop) r_remain <= r_remain - LEN_W'(1);
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // pkt_drop is high in DONE exactly when the packet was discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_cnt  <= '0;
      r_ev_addr <= '0;
    end else if (clear_ev) begin
      r_ev_cnt  <= '0;
      r_ev_addr <= '0;
    end else begin
      if (r_state == ST_DONE && w_is_ev && !r_pkt_drop && !ev_full)
        r_ev_cnt <= r_ev_cnt + c_CNT_W'(1);
      if (w_ev_we != '0)
        r_ev_addr <= r_ev_addr + EV_ADDR_W'(1);
    end
  end

  a2b_word_packer #(
    .DATA_W     (DATA_W),
    .PACK_RATIO (PACK_RATIO)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_ev_push),
    .i_last (w_last),
    .i_data (bus.src_dout),
    .o_we   (w_ev_we),
    .o_data (w_ev_data)
  );

  assign bus.src_rd_en = w_pop;
  assign bus.er_wr_en  = w_er_wr;
  assign bus.er_wr_din = w_er_din;
  assign bus.ev_wea    = w_ev_we;
  assign bus.ev_dina   = w_ev_data;
  assign bus.ev_addra  = r_ev_addr;
  assign pkt_done      = r_pkt_done;
  assign pkt_drop      = r_pkt_drop;
  assign state         = r_state;
endmodule

`default_nettype wire

// File: tb/tb_a2b_packet_router.sv
// ============================================================================
// tb_a2b_packet_router : scoreboard bench for ER/EV routing, drop and reset
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_a2b_packet_router;
  import a2b_packet_router_pkg::*;

  localparam int DATA_W       = 32;
  localparam int PACK_RATIO   = 2;
  localparam int EV_ADDR_W    = 14;
  localparam int EV_PKT_LIMIT = 32;
  localparam int LEN_W        = 11;
  localparam int WIDE_W       = PACK_RATIO * DATA_W;
  localparam logic [WIDE_W/8-1:0] WEA_ALL = '1;

  typedef struct packed {
    logic [EV_ADDR_W-1:0] addr;
    logic [WIDE_W-1:0]    data;
  } ev_item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_ev;
  logic       ev_full;
  logic       pkt_done;
  logic       pkt_drop;
  logic [2:0] state;

  a2b_packet_router_if #(.DATA_W(DATA_W), .PACK_RATIO(PACK_RATIO), .EV_ADDR_W(EV_ADDR_W)) bus();

  a2b_packet_router #(
    .DATA_W(DATA_W), .PACK_RATIO(PACK_RATIO), .EV_ADDR_W(EV_ADDR_W),
    .EV_PKT_LIMIT(EV_PKT_LIMIT), .LEN_W(LEN_W)
  ) u_dut (
    .clk(clk), .rst(rst), .clear_ev(clear_ev), .bus(bus),
    .ev_full(ev_full), .pkt_done(pkt_done), .pkt_drop(pkt_drop), .state(state)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]    src_q[$];
  logic [DATA_W-1:0]    er_exp[$];
  ev_item_t             ev_exp[$];
  bit                   done_exp[$];
  int                   checks, errors, done_cnt, exp_cnt;
  logic [EV_ADDR_W-1:0] exp_addr;
  bit                   pend, stall, clr_on_done, acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_src();
    bus.src_empty = stall || (src_q.size() == 0);
    bus.src_dout  = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic monitor();
    ev_item_t e;
    pend = bus.src_rd_en && !bus.src_empty;
    if (bus.src_rd_en) check("rd_while_empty", bus.src_empty, 0);
    if (bus.er_full) begin
      check("wr_while_full", bus.er_wr_en, 0);
      if (state == 3'd2) check("rd_while_full", bus.src_rd_en, 0);
    end
    if (bus.er_wr_en) begin
      check("er_pending", er_exp.size() != 0, 1);
      if (er_exp.size() != 0) check("er_data", bus.er_wr_din, er_exp.pop_front());
    end else begin
      check("er_din_idle", bus.er_wr_din, 0);
    end
    if (bus.ev_wea != '0) begin
      check("ev_wea", bus.ev_wea, WEA_ALL);
      check("ev_pending", ev_exp.size() != 0, 1);
      if (ev_exp.size() != 0) begin
        e = ev_exp.pop_front();
        check("ev_addr", bus.ev_addra, e.addr);
        check("ev_data", bus.ev_dina, e.data);
      end
    end
    if (pkt_done) begin
      done_cnt++;
      check("done_state", state, 3'd4);
      check("done_pending", done_exp.size() != 0, 1);
      if (done_exp.size() != 0) check("pkt_drop", pkt_drop, done_exp.pop_front());
      if (clr_on_done) begin
        clear_ev    = 1'b1;
        clr_on_done = 1'b0;
      end
    end else begin
      check("drop_alone", pkt_drop, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    clear_ev = 1'b0;
    if (pend) src_q.delete(0);
    pend = 1'b0;
    drive_src();
  endtask

  function automatic int model_len(input logic [3:0] code, input logic [8:0] slen);
    if (code == c_LEN_257)  return int'(slen);
    if (code == c_LEN_514)  return 512;
    if (code == c_LEN_771)  return 768;
    return 1024;
  endfunction

  task automatic push_pkt(input logic [3:0] ptype, input logic [3:0] code,
                          input logic [8:0] slen, output bit acc_ev);
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] w[$];
    logic [WIDE_W-1:0] d;
    bit                is_er;
    int                n;
    n      = model_len(code, slen);
    hdr    = {ptype, code, slen, 15'($urandom)};
    for (int i = 0; i < n; i++) w.push_back($urandom);
    is_er  = (ptype == c_TYPE_CORRECT_PARITY) || (ptype == c_TYPE_TARGET_HASHTAG);
    acc_ev = (ptype == c_TYPE_EV_RANDOMBIT) && (exp_cnt < EV_PKT_LIMIT);
    src_q.push_back(hdr);
    for (int i = 0; i < n; i++) src_q.push_back(w[i]);
    if (is_er) begin
      er_exp.push_back(hdr);
      for (int i = 0; i < n; i++) er_exp.push_back(w[i]);
    end
    if (acc_ev) begin
      for (int i = 0; i < n; i += PACK_RATIO) begin
        d = '0;
        for (int k = 0; k < PACK_RATIO; k++)
          if (i + k < n) d[WIDE_W - 1 - k*DATA_W -: DATA_W] = w[i+k];
        ev_exp.push_back('{addr: exp_addr, data: d});
        exp_addr = exp_addr + 1'b1;
      end
    end
    done_exp.push_back(!is_er && !acc_ev);
    drive_src();
  endtask

  task automatic wait_done(input int bound, input bit acc_ev, input bit clr);
    int start;
    int n;
    start       = done_cnt;
    n           = 0;
    clr_on_done = clr;
    while (done_cnt == start && n < bound) begin
      tick();
      n++;
    end
    check("done_timeout", done_cnt != start, 1);
    if (clr) begin
      exp_cnt  = 0;
      exp_addr = '0;
    end else if (acc_ev) begin
      exp_cnt++;
    end
    check("idle_after", state, 3'd0);
    check("ev_full", ev_full, exp_cnt == EV_PKT_LIMIT);
  endtask

  task automatic send(input logic [3:0] ptype, input logic [3:0] code,
                      input logic [8:0] slen, input bit clr);
    bit a;
    push_pkt(ptype, code, slen, a);
    wait_done(model_len(code, slen) + 64, a, clr);
  endtask

  initial begin
    rst = 1'b1; clear_ev = 1'b0; stall = 1'b0; bus.er_full = 1'b0;
    checks = 0; errors = 0; done_cnt = 0; exp_cnt = 0; exp_addr = '0;
    pend = 1'b0; clr_on_done = 1'b0;
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_rd", bus.src_rd_en, 0);
    check("rst_wea", bus.ev_wea, 0);
    check("rst_addr", bus.ev_addra, 0);
    check("rst_full", ev_full, 0);
    check("rst_done", pkt_done, 0);
    rst = 1'b0;
    tick();

    send(c_TYPE_CORRECT_PARITY, c_LEN_257, 9'd5, 1'b0);
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd5, 1'b0);

    push_pkt(c_TYPE_TARGET_HASHTAG, c_LEN_514, 9'd0, acc);
    repeat (100) tick();
    bus.er_full = 1'b1;
    repeat (10) tick();
    bus.er_full = 1'b0;
    wait_done(600, acc, 1'b0);

    send(4'hF, 4'h0, 9'd0, 1'b0);
    send(c_TYPE_CORRECT_PARITY, c_LEN_257, 9'd7, 1'b0);
    send(c_TYPE_TARGET_HASHTAG, c_LEN_257, 9'd0, 1'b0);
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd0, 1'b0);
    send(c_TYPE_CORRECT_PARITY, c_LEN_771, 9'd0, 1'b0);

    while (exp_cnt < EV_PKT_LIMIT)
      send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'($urandom_range(1, 4)), 1'b0);
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd6, 1'b0);

    clear_ev = 1'b1;
    tick();
    exp_cnt  = 0;
    exp_addr = '0;
    check("clr_full", ev_full, 0);
    check("clr_addr", bus.ev_addra, 0);

    // clear lands on the DONE cycle that also carries the padded final write
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd3, 1'b1);
    check("clr_done_addr", bus.ev_addra, 0);
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd2, 1'b0);

    push_pkt(c_TYPE_EV_RANDOMBIT, c_LEN_514, 9'd0, acc);
    repeat (60) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_rd", bus.src_rd_en, 0);
    check("arst_erwr", bus.er_wr_en, 0);
    check("arst_erdin", bus.er_wr_din, 0);
    check("arst_wea", bus.ev_wea, 0);
    check("arst_addr", bus.ev_addra, 0);
    check("arst_dina", bus.ev_dina, 0);
    check("arst_done", pkt_done, 0);
    check("arst_drop", pkt_drop, 0);
    check("arst_full", ev_full, 0);
    src_q.delete(); er_exp.delete(); ev_exp.delete(); done_exp.delete();
    exp_cnt = 0; exp_addr = '0;
    drive_src();
    tick();
    tick();
    rst = 1'b0;

    send(c_TYPE_CORRECT_PARITY, c_LEN_257, 9'd4, 1'b0);
    send(c_TYPE_EV_RANDOMBIT, c_LEN_257, 9'd3, 1'b0);
    repeat (3) tick();

    check("er_left", er_exp.size(), 0);
    check("ev_left", ev_exp.size(), 0);
    check("done_left", done_exp.size(), 0);
    check("src_left", src_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/a2b_packet_router.md
A2B_PACKET_ROUTER -- requirements
Module: a2b_packet_router

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 32, source/ER word width.
- PACK_RATIO, 2, source words packed per EV BRAM word.
- EV_ADDR_W, 14, EV BRAM address width.
- EV_PKT_LIMIT, 32, EV packets accepted before ev_full.
- LEN_W, 11, payload counter width (max 1024).
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- clear_ev, in, 1, sync clear of EV address and EV packet count.
- src_empty, in, 1, source FIFO empty (FWFT).
- src_dout, in, DATA_W, source head word, valid when !src_empty.
- src_rd_en, out, 1, pop source.
- er_full, in, 1, ER FIFO full.
- er_wr_en, out, 1, ER FIFO write.
- er_wr_din, out, DATA_W, ER FIFO data.
- ev_wea, out, PACK_RATIO*DATA_W/8, EV BRAM byte write enable.
- ev_addra, out, EV_ADDR_W, EV BRAM address.
- ev_dina, out, PACK_RATIO*DATA_W, EV BRAM data.
- ev_full, out, 1, EV packet count equals EV_PKT_LIMIT.
- pkt_done, out, 1, one-cycle pulse per packet completed.
- pkt_drop, out, 1, one-cycle pulse per packet dropped.
- state, out, 3, current FSM state.

Function
REQ-003 Header field decode SHALL be: type = [31:28]; length code = [27:24]; short length = [23:15].
REQ-004 Payload length SHALL be: code LEN_257 -> short length (0..511); LEN_514 -> 512; LEN_771 -> 768; LEN_1028 -> 1024; any other code -> 1024.
REQ-005 A pop SHALL occur only when src_rd_en=1 and src_empty=0.
- src_rd_en SHALL never assert while src_empty=1.
REQ-006 FSM states SHALL be IDLE=0, HEADER=1, PAYLOAD=2, DROP=3, DONE=4.
REQ-007 IDLE: when !src_empty, the FSM SHALL pop the header, latch it, load the remaining-word count, and go to HEADER.
REQ-008 HEADER routing SHALL depend on packet type:
- ER type (CORRECT_PARITY, TARGET_HASHTAG): write the latched header to the ER FIFO in the first cycle with er_full=0, then go to PAYLOAD.
- EV_RANDOMBIT with ev_full=0: go to PAYLOAD; the header is not written anywhere.
- EV_RANDOMBIT with ev_full=1, or any other type: go to DROP.
REQ-009 When the payload length is 0, PAYLOAD and DROP SHALL go straight to DONE without popping.
REQ-010 PAYLOAD, ER type: src_rd_en = !src_empty & !er_full.
- er_wr_en SHALL equal the pop, same cycle; er_wr_din = src_dout.
- er_wr_din SHALL be 0 when er_wr_en=0.
REQ-011 PAYLOAD, EV type: src_rd_en = !src_empty, with no backpressure.
- Words SHALL be packed MSB-first; the first word of a group goes in the top DATA_W slice.
REQ-012 EV BRAM write timing and addressing:
- A BRAM write SHALL fire one cycle after the pop that completes a group, with ev_wea all ones.
- ev_addra SHALL increment after each write and wrap modulo 2^EV_ADDR_W.
REQ-013 A partial final group SHALL be zero-padded in its low slices and written one cycle after the last pop.
REQ-014 DROP SHALL pop payload words until the count reaches 0, then go to DONE with pkt_drop asserted for one cycle.
REQ-015 The FSM SHALL go from PAYLOAD to DONE on the pop of the last word.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE.
- It SHALL pulse pkt_done for every packet, including dropped ones.
- It SHALL increment the EV packet count for accepted EV packets; the count saturates at EV_PKT_LIMIT.
REQ-017 clear_ev SHALL zero ev_addra and the EV packet count.
- clear_ev SHALL win over a simultaneous increment or write-address advance.
- The EV data write itself SHALL still occur.
REQ-018 Outputs ev_wea, ev_dina, pkt_done and pkt_drop SHALL be registered.
- src_rd_en, er_wr_en and er_wr_din SHALL be combinational from state and inputs.

Reset
REQ-019 On rst, the following SHALL reset asynchronously: state to IDLE, and to 0 the latched header, counters, pack buffer, ev_addra, ev_wea, ev_dina, pkt_done, pkt_drop and the EV count.
REQ-020 On reset mid-packet, the in-flight packet and any partial pack group SHALL be discarded.
- After rst deasserts, the next source word SHALL be treated as a header.

Structure
REQ-021 The following SHALL live in the shared packet package: packet type codes, length codes, header field positions, and the FSM state encoding.
REQ-022 Word packing SHALL be a sub-module a2b_word_packer (parameters DATA_W, PACK_RATIO).
- Inputs: push, last, data.
- Outputs: registered wide write strobe and data.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- ER packet, code LEN_257, short length 5, er_full=0 -> 6 ER writes (header, then 5 words in order), then pkt_done.
- ER packet, length 512, er_full held high for 10 cycles mid-payload -> no pops or writes while full, all 513 words delivered in order.
- EV packet, length 5, PACK_RATIO=2 -> 3 BRAM writes at addresses 0, 1, 2; the last is {w4, 0}; header not written; EV count = 1.
- 32 EV packets, then a 33rd -> ev_full=1 after the 32nd; the 33rd gets pkt_drop, all its words are popped, and no BRAM write occurs.
- Unknown type 0xF, code 0 -> 1024 payload words dropped, then pkt_drop; following ER packet routed correctly.
- rst asserted mid-EV payload -> state returns to IDLE asynchronously and all outputs go to 0; clear_ev in a DONE cycle -> EV count = 0.
